// File: rtl/matmul_result_serializer.sv
// Captures a full-width matmul result vector on done_i and streams it out one
// OUTPUT_WIDTH word per valid/ready beat, ascending index order.
module matmul_result_serializer #(
  parameter int OUTPUT_WIDTH = 32,
  parameter int WORDS        = 8,
  parameter int IDX_W        = 3
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          done_i,
  input  logic [OUTPUT_WIDTH*WORDS-1:0] matmul_i,
  input  logic                          clr_i,
  input  logic                          ready_i,
  output logic                          valid_o,
  output logic [OUTPUT_WIDTH-1:0]       data_o,
  output logic [IDX_W-1:0]              idx_o,
  output logic                          last_o,
  output logic                          busy_o,
  output logic                          ovf_o
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    ovf_q, ovf_d;
  logic                    capture;
  logic                    xfer;
  logic                    final_xfer;
  logic                    drop;
  logic [OUTPUT_WIDTH-1:0] buf_q [WORDS];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < WORDS; k++) buf_q[k] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      if (capture) begin
        for (int k = 0; k < WORDS; k++) buf_q[k] <= matmul_i[k*OUTPUT_WIDTH +: OUTPUT_WIDTH];
      end
    end
  end

  assign xfer       = (state_q == SEND) && ready_i;
  assign final_xfer = xfer && (idx_q == LAST_IDX);
  // A done pulse is only accepted when the buffer is free or being freed this edge.
  assign drop       = (state_q == SEND) && done_i && !final_xfer;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (done_i) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (final_xfer) begin
          idx_d = '0;
          if (done_i) capture = 1'b1;
          else        state_d = IDLE;
        end else if (xfer) begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    ovf_d = ovf_q;
    if (clr_i) ovf_d = 1'b0;
    if (drop)  ovf_d = 1'b1;
  end

  always_comb begin
    valid_o = (state_q == SEND);
    busy_o  = (state_q == SEND);
    data_o  = '0;
    last_o  = 1'b0;
    if (state_q == SEND) begin
      data_o = buf_q[idx_q];
      last_o = (idx_q == LAST_IDX);
    end
    idx_o = idx_q;
    ovf_o = ovf_q;
  end

endmodule

// File: tb/tb_matmul_result_serializer.sv
// Scoreboard bench for matmul_result_serializer: expected beats are queued when
// a vector is offered and compared as each handshake completes.
module tb_matmul_result_serializer;

  localparam int OW    = 32;
  localparam int WORDS = 8;
  localparam int IDX_W = 3;

  logic                  clk_i = 1'b0;
  logic                  rstn_i = 1'b0;
  logic                  done_i = 1'b0;
  logic [OW*WORDS-1:0]   matmul_i = '0;
  logic                  clr_i = 1'b0;
  logic                  ready_i = 1'b0;
  logic                  valid_o;
  logic [OW-1:0]         data_o;
  logic [IDX_W-1:0]      idx_o;
  logic                  last_o;
  logic                  busy_o;
  logic                  ovf_o;

  typedef struct packed {
    logic [OW-1:0]    d;
    logic [IDX_W-1:0] i;
    logic             l;
  } beat_t;

  beat_t exp_q[$];
  int    n_chk  = 0;
  int    n_pass = 0;

  matmul_result_serializer #(.OUTPUT_WIDTH(OW), .WORDS(WORDS), .IDX_W(IDX_W)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .done_i(done_i), .matmul_i(matmul_i),
    .clr_i(clr_i), .ready_i(ready_i), .valid_o(valid_o), .data_o(data_o),
    .idx_o(idx_o), .last_o(last_o), .busy_o(busy_o), .ovf_o(ovf_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [OW*WORDS-1:0] mkvec(input logic [OW-1:0] base);
    logic [OW*WORDS-1:0] v;
    for (int k = 0; k < WORDS; k++) v[k*OW +: OW] = base + OW'(k);
    return v;
  endfunction

  task automatic push_vec(input logic [OW-1:0] base);
    for (int k = 0; k < WORDS; k++)
      exp_q.push_back('{d: base + OW'(k), i: IDX_W'(k), l: (k == WORDS-1)});
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  // Offer a vector; the caller decides whether it is expected to be accepted.
  task automatic offer(input logic [OW-1:0] base, input bit accept);
    done_i   = 1'b1;
    matmul_i = mkvec(base);
    if (accept) push_vec(base);
    tick();
    done_i = 1'b0;
  endtask

  task automatic wait_idx(input int n);
    for (int c = 0; c < 100; c++) begin
      if (valid_o && idx_o == IDX_W'(n)) return;
      tick();
    end
    chk("wait_idx_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_drain;
    for (int c = 0; c < 200; c++) begin
      if (exp_q.size() == 0 && !valid_o) begin
        chk("drain_busy", 64'(busy_o), 64'd0);
        return;
      end
      tick();
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 64'(valid_o), 64'd0);
    chk({tag, "_data"},  64'(data_o),  64'd0);
    chk({tag, "_idx"},   64'(idx_o),   64'd0);
    chk({tag, "_last"},  64'(last_o),  64'd0);
    chk({tag, "_busy"},  64'(busy_o),  64'd0);
    chk({tag, "_ovf"},   64'(ovf_o),   64'd0);
  endtask

  // Monitor: a beat transfers at the next rising edge when valid && ready.
  always @(negedge clk_i) begin
    if (rstn_i && valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 64'(data_o), 64'hDEAD);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("beat_data", 64'(data_o), 64'(e.d));
        chk("beat_idx",  64'(idx_o),  64'(e.i));
        chk("beat_last", 64'(last_o), 64'(e.l));
      end
    end
  end

  initial begin
    // Reset values with inputs toggling
    for (int c = 0; c < 4; c++) begin
      done_i  = c[0];
      ready_i = c[1];
      matmul_i = mkvec(32'h5555_0000);
      #1;
      chk_all_zero("rst");
      tick();
    end
    done_i = 1'b0;
    ready_i = 1'b0;
    rstn_i = 1'b1;
    tick();

    // Basic drain with latency-1 first word
    ready_i = 1'b1;
    done_i = 1'b1;
    matmul_i = mkvec(32'h1000_0000);
    push_vec(32'h1000_0000);
    chk("lat_pre_valid", 64'(valid_o), 64'd0);
    tick();
    done_i = 1'b0;
    chk("lat_valid", 64'(valid_o), 64'd1);
    chk("lat_idx", 64'(idx_o), 64'd0);
    chk("lat_busy", 64'(busy_o), 64'd1);
    wait_drain();
    chk("basic_ovf", 64'(ovf_o), 64'd0);

    // Backpressure: stall on idx 2 for three cycles
    offer(32'h1000_0000, 1'b1);
    tick();
    tick();
    ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("stall_valid", 64'(valid_o), 64'd1);
      chk("stall_idx", 64'(idx_o), 64'd2);
      chk("stall_data", 64'(data_o), 64'h1000_0002);
      tick();
    end
    ready_i = 1'b1;
    wait_drain();

    // Back-to-back: new vector on the final-beat transfer cycle
    offer(32'h1000_0000, 1'b1);
    wait_idx(WORDS - 1);
    offer(32'h0000_00A0, 1'b1);
    chk("b2b_valid", 64'(valid_o), 64'd1);
    chk("b2b_idx", 64'(idx_o), 64'd0);
    chk("b2b_data", 64'(data_o), 64'hA0);
    chk("b2b_ovf", 64'(ovf_o), 64'd0);
    wait_drain();

    // Overflow: drop at idx 3, first vector continues
    offer(32'h1000_0000, 1'b1);
    wait_idx(3);
    offer(32'h0000_00BB, 1'b0);
    chk("ovf_set", 64'(ovf_o), 64'd1);
    wait_drain();
    chk("ovf_sticky", 64'(ovf_o), 64'd1);
    // Simultaneous clear and drop: set wins
    offer(32'h2000_0000, 1'b1);
    wait_idx(2);
    clr_i = 1'b1;
    offer(32'h0000_00CC, 1'b0);
    clr_i = 1'b0;
    chk("ovf_set_wins", 64'(ovf_o), 64'd1);
    wait_drain();
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    chk("ovf_clr", 64'(ovf_o), 64'd0);

    // Mid-drain asynchronous reset at idx 5
    offer(32'h5000_0000, 1'b1);
    wait_idx(5);
    rstn_i = 1'b0;
    exp_q.delete();
    #1;
    chk_all_zero("mid_rst");
    for (int c = 0; c < 3; c++) begin
      done_i  = ~done_i;
      ready_i = ~ready_i;
      tick();
      chk("mid_rst_valid", 64'(valid_o), 64'd0);
      chk("mid_rst_data", 64'(data_o), 64'd0);
    end
    done_i = 1'b0;
    ready_i = 1'b1;
    rstn_i = 1'b1;
    tick();
    offer(32'h7000_0000, 1'b1);
    chk("post_rst_idx", 64'(idx_o), 64'd0);
    chk("post_rst_data", 64'(data_o), 64'h7000_0000);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/matmul_result_serializer.md
Name: matmul_result_serializer

Overview:
Read side of the Matrix_Multiplier result interface. Captures a full-width result vector (matmul_o/done_o of a multiplier stage) on its done pulse, then emits it one OUTPUT_WIDTH word per beat over a valid/ready stream to a narrow downstream consumer (bus writer, output FIFO). Sits directly after the second multiplier stage of the chained matmul datapath.

Parameters:
OUTPUT_WIDTH, 32, width of one result element / output word
WORDS, 8, number of elements per result vector (= maccnt of the upstream multiplier)
IDX_W, 3, width of word index; must satisfy 2**IDX_W >= WORDS

Ports:
clk_i  input  1  clock, all logic on rising edge
rstn_i  input  1  asynchronous active-low reset
done_i  input  1  one-cycle pulse: matmul_i holds a valid result this cycle
matmul_i  input  OUTPUT_WIDTH*WORDS  result vector; element k = bits [k*OUTPUT_WIDTH +: OUTPUT_WIDTH]
clr_i  input  1  synchronous clear of ovf_o
ready_i  input  1  downstream accepts the current word
valid_o  output  1  data_o holds a valid word
data_o  output  OUTPUT_WIDTH  current word
idx_o  output  IDX_W  element index of data_o
last_o  output  1  data_o is element WORDS-1
busy_o  output  1  result captured and not fully drained
ovf_o  output  1  sticky: a done_i pulse was dropped

Behaviour:
- Reset (async, rstn_i low): state IDLE; valid_o, last_o, busy_o, ovf_o = 0; data_o = 0; idx_o = 0; capture buffer = 0. Takes effect immediately, including mid-drain; the partially sent vector is discarded.
- Handshake: a beat transfers on a rising edge with valid_o && ready_i. While valid_o=1 and ready_i=0, data_o, idx_o, last_o are held stable. valid_o never drops without a transfer.
- States: IDLE, SEND.
- IDLE: valid_o=0, busy_o=0, data_o=0. done_i=1 -> register matmul_i into buffer, idx=0, go to SEND. First word is valid on the cycle after done_i (latency 1).
- SEND: valid_o=1, busy_o=1, data_o = buffer element idx, last_o = (idx==WORDS-1). On transfer with idx<WORDS-1: idx+1. On transfer with idx==WORDS-1: if done_i is high in that same cycle, capture the new matmul_i, idx=0, stay in SEND with no bubble; otherwise go to IDLE.
- Overflow: done_i in SEND other than on the final-beat transfer cycle -> vector dropped, buffer unchanged, ovf_o set on the next edge. ovf_o stays 1 until clr_i=1. If clr_i and a new drop happen in the same cycle, set wins.
- ready_i is don't-care in IDLE. Words leave in ascending index order 0..WORDS-1. Elements pass through unmodified: no truncation, no sign handling.
- Throughput: one vector per WORDS cycles when ready_i is held high and done_i lands on each final beat.

Test Plan:
- Basic drain: reset, done_i with element k = 32'h1000_0000+k, ready_i=1 -> valid_o from next cycle for 8 cycles, data_o 10000000..10000007, idx_o 0..7, last_o only on idx 7, then valid_o=0, busy_o=0.
- Backpressure: same vector, ready_i low on cycles 2-4 of the drain -> data_o/idx_o frozen at idx 2 while stalled; all 8 words delivered once each, in order.
- Back-to-back: second done_i (elements 32'hA0+k) on the cycle idx 7 transfers -> idx 0 of the new vector on the next cycle with valid_o continuous; no ovf_o.
- Overflow: done_i (elements 32'hBB+k) while idx=3 -> ovf_o=1 next cycle; remaining words are still the first vector; clr_i pulse -> ovf_o=0.
- Mid-drain reset: assert rstn_i low at idx=5 -> all outputs 0 immediately; after release, a new done_i drains from idx 0 correctly.
- Reset values: check every output is 0 while rstn_i is low, with done_i and ready_i toggling.
